riscv_pipe_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage RV64IMC pipeline. It drives the hold (en) and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC register. It arbitrates between trap entry and return, data-cache wait, multi-cycle divide, load-use hazard and branch mispredict. The block sits beside the hazard unit in the core top level.

---
 rtl/riscv_pipe_ctrl_if.sv | 49 ++++
 rtl/riscv_pipe_ctrl.sv | 174 +++++++++++++++++
 tb/tb_riscv_pipe_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/riscv_pipe_ctrl_if.sv
// ----------------------------------------------------------------------------
// riscv_pipe_ctrl_if
// Bundles the pipeline events seen by the stall/flush sequencer and the
// hold/bubble/redirect controls it returns to the pipeline registers.
//   master : the sequencer (consumes events, drives stall/flush controls)
//   slave  : the pipeline/core side (drives events, consumes controls)
// ----------------------------------------------------------------------------
interface riscv_pipe_ctrl_if;
    // Events from the pipeline
    logic i_riscv_pctrl_trap_wb;
    logic i_riscv_pctrl_memstall_m;
    logic i_riscv_pctrl_divstart_e;
    logic i_riscv_pctrl_loaduse_d;
    logic i_riscv_pctrl_mispredict_e;
    // Controls back to the pipeline
    logic o_riscv_pctrl_stall_pc;
    logic o_riscv_pctrl_stall_fd;
    logic o_riscv_pctrl_stall_de;
    logic o_riscv_pctrl_stall_em;
    logic o_riscv_pctrl_stall_mw;
    logic o_riscv_pctrl_flush_fd;
    logic o_riscv_pctrl_flush_de;
    logic o_riscv_pctrl_flush_em;
    logic o_riscv_pctrl_flush_mw;
    logic o_riscv_pctrl_pcsel_trap;
    logic o_riscv_pctrl_div_done;
    logic o_riscv_pctrl_div_kill;
    logic o_riscv_pctrl_dcache_abort;

    modport master (
        input  i_riscv_pctrl_trap_wb, i_riscv_pctrl_memstall_m, i_riscv_pctrl_divstart_e,
               i_riscv_pctrl_loaduse_d, i_riscv_pctrl_mispredict_e,
        output o_riscv_pctrl_stall_pc, o_riscv_pctrl_stall_fd, o_riscv_pctrl_stall_de,
               o_riscv_pctrl_stall_em, o_riscv_pctrl_stall_mw,
               o_riscv_pctrl_flush_fd, o_riscv_pctrl_flush_de, o_riscv_pctrl_flush_em,
               o_riscv_pctrl_flush_mw, o_riscv_pctrl_pcsel_trap, o_riscv_pctrl_div_done,
               o_riscv_pctrl_div_kill, o_riscv_pctrl_dcache_abort
    );

    modport slave (
        output i_riscv_pctrl_trap_wb, i_riscv_pctrl_memstall_m, i_riscv_pctrl_divstart_e,
               i_riscv_pctrl_loaduse_d, i_riscv_pctrl_mispredict_e,
        input  o_riscv_pctrl_stall_pc, o_riscv_pctrl_stall_fd, o_riscv_pctrl_stall_de,
               o_riscv_pctrl_stall_em, o_riscv_pctrl_stall_mw,
               o_riscv_pctrl_flush_fd, o_riscv_pctrl_flush_de, o_riscv_pctrl_flush_em,
               o_riscv_pctrl_flush_mw, o_riscv_pctrl_pcsel_trap, o_riscv_pctrl_div_done,
               o_riscv_pctrl_div_kill, o_riscv_pctrl_dcache_abort
    );
endinterface

// File: rtl/riscv_pipe_ctrl.sv
// ----------------------------------------------------------------------------
// riscv_pipe_ctrl
// Stall/flush sequencer for the 5-stage pipeline. Arbitrates trap redirect,
// dcache wait, multi-cycle divide, load-use hazard and branch mispredict, and
// drives hold/bubble controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
// Controls are combinational so they act in the same cycle as the event.
// Ports:
//   i_riscv_pctrl_clk : core clock
//   i_riscv_pctrl_rst : asynchronous reset, active-high (forces bubbles)
//   bus               : riscv_pipe_ctrl_if.master, events in / controls out
// ----------------------------------------------------------------------------
module riscv_pipe_ctrl #(
    parameter int DIV_LAT     = 33,
    parameter int TRAP_REFILL = 2
) (
    input  logic                  i_riscv_pctrl_clk,
    input  logic                  i_riscv_pctrl_rst,
    riscv_pipe_ctrl_if.master     bus
);
    localparam int MAX_CNT = (DIV_LAT > TRAP_REFILL) ? DIV_LAT : TRAP_REFILL;
    localparam int CW      = $clog2(MAX_CNT + 1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DIV    = 2'd1,
        ST_MEM    = 2'd2,
        ST_REFILL = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic trap_s, mem_s, div_s, lu_s, mp_s;
    logic stall_pc_s, stall_fd_s, stall_de_s, stall_em_s, stall_mw_s;
    logic flush_fd_s, flush_de_s, flush_em_s, flush_mw_s;
    logic pcsel_s, done_s, kill_s, abort_s;

    assign trap_s = bus.i_riscv_pctrl_trap_wb;
    assign mem_s  = bus.i_riscv_pctrl_memstall_m;
    assign div_s  = bus.i_riscv_pctrl_divstart_e;
    assign lu_s   = bus.i_riscv_pctrl_loaduse_d;
    assign mp_s   = bus.i_riscv_pctrl_mispredict_e;

    // State and counter register
    always_ff @(posedge i_riscv_pctrl_clk or posedge i_riscv_pctrl_rst) begin
        if (i_riscv_pctrl_rst) begin
            state_q <= ST_RUN;
            cnt_q   <= {CW{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and counter update
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (trap_s) begin
            state_d = ST_REFILL;
            cnt_d   = CW'(TRAP_REFILL - 1);
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (mem_s) begin
                        state_d = ST_MEM;
                    end else if (div_s) begin
                        state_d = ST_DIV;
                        cnt_d   = CW'(DIV_LAT - 2);
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_MEM: begin
                    if (mem_s) begin
                        state_d = ST_MEM;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_DIV: begin
                    // At zero the result waits for the dcache before it is handed over
                    if (cnt_q == {CW{1'b0}}) begin
                        if (mem_s) begin
                            state_d = ST_DIV;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                ST_REFILL: begin
                    if (cnt_q == {CW{1'b0}}) begin
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    cnt_d   = {CW{1'b0}};
                end
            endcase
        end
    end

    // Stall/flush decode; no register ever sees stall and flush together
    always_comb begin
        stall_pc_s = 1'b0; stall_fd_s = 1'b0; stall_de_s = 1'b0;
        stall_em_s = 1'b0; stall_mw_s = 1'b0;
        flush_fd_s = 1'b0; flush_de_s = 1'b0; flush_em_s = 1'b0; flush_mw_s = 1'b0;
        pcsel_s    = 1'b0; done_s     = 1'b0; kill_s     = 1'b0; abort_s    = 1'b0;
        if (i_riscv_pctrl_rst) begin
            flush_fd_s = 1'b1; flush_de_s = 1'b1; flush_em_s = 1'b1; flush_mw_s = 1'b1;
        end else if (trap_s) begin
            flush_fd_s = 1'b1; flush_de_s = 1'b1; flush_em_s = 1'b1; flush_mw_s = 1'b1;
            pcsel_s    = 1'b1;
            kill_s     = (state_q == ST_DIV);
            abort_s    = mem_s;
        end else begin
            case (state_q)
                ST_RUN, ST_MEM: begin
                    if (mem_s) begin
                        stall_pc_s = 1'b1; stall_fd_s = 1'b1; stall_de_s = 1'b1;
                        stall_em_s = 1'b1; flush_mw_s = 1'b1;
                    end else if (div_s && (state_q == ST_RUN)) begin
                        stall_pc_s = 1'b1; stall_fd_s = 1'b1; stall_de_s = 1'b1;
                        flush_em_s = 1'b1;
                    end else if (mp_s) begin
                        // Mispredict squashes the load-use victim, so no stall is needed
                        flush_fd_s = 1'b1; flush_de_s = 1'b1;
                    end else if (lu_s) begin
                        stall_pc_s = 1'b1; stall_fd_s = 1'b1; flush_de_s = 1'b1;
                    end else begin
                        stall_pc_s = 1'b0;
                    end
                end
                ST_DIV: begin
                    if (mem_s) begin
                        // Hold the older load/store in MEM; EX/MEM keeps it too
                        stall_pc_s = 1'b1; stall_fd_s = 1'b1; stall_de_s = 1'b1;
                        stall_em_s = 1'b1; flush_mw_s = 1'b1;
                    end else if (cnt_q == {CW{1'b0}}) begin
                        done_s = 1'b1;
                    end else begin
                        stall_pc_s = 1'b1; stall_fd_s = 1'b1; stall_de_s = 1'b1;
                        flush_em_s = 1'b1;
                    end
                end
                ST_REFILL: begin
                    flush_fd_s = 1'b1;
                end
                default: begin
                    flush_fd_s = 1'b1; flush_de_s = 1'b1; flush_em_s = 1'b1; flush_mw_s = 1'b1;
                end
            endcase
        end
    end

    assign bus.o_riscv_pctrl_stall_pc     = stall_pc_s;
    assign bus.o_riscv_pctrl_stall_fd     = stall_fd_s;
    assign bus.o_riscv_pctrl_stall_de     = stall_de_s;
    assign bus.o_riscv_pctrl_stall_em     = stall_em_s;
    assign bus.o_riscv_pctrl_stall_mw     = stall_mw_s;
    assign bus.o_riscv_pctrl_flush_fd     = flush_fd_s;
    assign bus.o_riscv_pctrl_flush_de     = flush_de_s;
    assign bus.o_riscv_pctrl_flush_em     = flush_em_s;
    assign bus.o_riscv_pctrl_flush_mw     = flush_mw_s;
    assign bus.o_riscv_pctrl_pcsel_trap   = pcsel_s;
    assign bus.o_riscv_pctrl_div_done     = done_s;
    assign bus.o_riscv_pctrl_div_kill     = kill_s;
    assign bus.o_riscv_pctrl_dcache_abort = abort_s;
endmodule

// File: tb/tb_riscv_pipe_ctrl.sv
// ----------------------------------------------------------------------------
// tb_riscv_pipe_ctrl
// Directed bench for riscv_pipe_ctrl (DIV_LAT=33, TRAP_REFILL=2). Each step
// drives the five events just after a rising edge, queues the expected
// control vector, and compares it on the falling edge.
// Control vector bit order (MSB..LSB):
//   stall_pc stall_fd stall_de stall_em stall_mw flush_fd flush_de flush_em
//   flush_mw pcsel_trap div_done div_kill dcache_abort
// Event vector: {trap_wb, memstall_m, divstart_e, loaduse_d, mispredict_e}
// ----------------------------------------------------------------------------
module tb_riscv_pipe_ctrl;
    localparam logic [12:0] NONE  = 13'h0000;
    localparam logic [12:0] S_PC  = 13'h1000;
    localparam logic [12:0] S_FD  = 13'h0800;
    localparam logic [12:0] S_DE  = 13'h0400;
    localparam logic [12:0] S_EM  = 13'h0200;
    localparam logic [12:0] F_FD  = 13'h0080;
    localparam logic [12:0] F_DE  = 13'h0040;
    localparam logic [12:0] F_EM  = 13'h0020;
    localparam logic [12:0] F_MW  = 13'h0010;
    localparam logic [12:0] PCSEL = 13'h0008;
    localparam logic [12:0] DONE  = 13'h0004;
    localparam logic [12:0] KILL  = 13'h0002;
    localparam logic [12:0] ABORT = 13'h0001;
    localparam logic [12:0] F_ALL = F_FD | F_DE | F_EM | F_MW;
    localparam logic [12:0] MEMST = S_PC | S_FD | S_DE | S_EM | F_MW;
    localparam logic [12:0] DIVST = S_PC | S_FD | S_DE | F_EM;
    localparam logic [12:0] LUST  = S_PC | S_FD | F_DE;

    localparam logic [4:0] I_IDLE = 5'b00000;
    localparam logic [4:0] I_TRAP = 5'b10000;
    localparam logic [4:0] I_MEM  = 5'b01000;
    localparam logic [4:0] I_DIV  = 5'b00100;
    localparam logic [4:0] I_LU   = 5'b00010;
    localparam logic [4:0] I_MP   = 5'b00001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [12:0] exp_q[$];
    string       tag_q[$];

    riscv_pipe_ctrl_if bus ();

    riscv_pipe_ctrl #(.DIV_LAT(33), .TRAP_REFILL(2)) dut (
        .i_riscv_pctrl_clk (clk),
        .i_riscv_pctrl_rst (rst),
        .bus               (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] observed();
        return {bus.o_riscv_pctrl_stall_pc, bus.o_riscv_pctrl_stall_fd,
                bus.o_riscv_pctrl_stall_de, bus.o_riscv_pctrl_stall_em,
                bus.o_riscv_pctrl_stall_mw, bus.o_riscv_pctrl_flush_fd,
                bus.o_riscv_pctrl_flush_de, bus.o_riscv_pctrl_flush_em,
                bus.o_riscv_pctrl_flush_mw, bus.o_riscv_pctrl_pcsel_trap,
                bus.o_riscv_pctrl_div_done, bus.o_riscv_pctrl_div_kill,
                bus.o_riscv_pctrl_dcache_abort};
    endfunction

    task automatic step(input logic [4:0] ev, input logic [12:0] exp, input string tag);
        logic [12:0] e;
        logic [12:0] o;
        string       t;
        @(posedge clk);
        #1;
        {bus.i_riscv_pctrl_trap_wb, bus.i_riscv_pctrl_memstall_m, bus.i_riscv_pctrl_divstart_e,
         bus.i_riscv_pctrl_loaduse_d, bus.i_riscv_pctrl_mispredict_e} = ev;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(negedge clk);
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        o = observed();
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", t, o, e);
        end
    endtask

    initial begin
        {bus.i_riscv_pctrl_trap_wb, bus.i_riscv_pctrl_memstall_m, bus.i_riscv_pctrl_divstart_e,
         bus.i_riscv_pctrl_loaduse_d, bus.i_riscv_pctrl_mispredict_e} = I_IDLE;

        // Reset forces bubbles whatever the events are
        step(I_IDLE, F_ALL, "rst_idle");
        step(I_MEM | I_DIV, F_ALL, "rst_events");
        @(posedge clk); #2; rst = 1'b0;
        for (int i = 0; i < 3; i++) step(I_IDLE, NONE, "idle_after_rst");

        // Dcache wait for four cycles
        for (int i = 0; i < 4; i++) step(I_MEM, MEMST, "memstall");
        step(I_IDLE, NONE, "mem_release");

        // Full divide: 32 stalled cycles then one done cycle
        step(I_DIV, DIVST, "div_start");
        for (int i = 0; i < 31; i++) begin
            if (i == 10) step(I_DIV | I_LU | I_MP, DIVST, "div_ignores_events");
            else         step(I_IDLE, DIVST, "div_wait");
        end
        step(I_IDLE, DONE, "div_done");
        step(I_IDLE, NONE, "div_after");

        // Hazard arbitration in RUN
        step(I_LU, LUST, "loaduse");
        step(I_MP, F_FD | F_DE, "mispredict");
        step(I_LU | I_MP, F_FD | F_DE, "lu_and_mp");
        step(I_MEM | I_LU | I_MP, MEMST, "mem_over_hazards");
        step(I_MP, F_FD | F_DE, "memwait_exit_mp");

        // Trap in the middle of a divide
        step(I_DIV, DIVST, "div2_start");
        for (int i = 0; i < 9; i++) step(I_IDLE, DIVST, "div2_wait");
        step(I_TRAP, F_ALL | PCSEL | KILL, "trap_in_div");
        step(I_MEM | I_DIV, F_FD, "refill1_ignores");
        step(I_IDLE, F_FD, "refill2");
        for (int i = 0; i < 30; i++) step(I_IDLE, NONE, "no_done_after_kill");

        // Trap together with a dcache stall
        step(I_TRAP | I_MEM, F_ALL | PCSEL | ABORT, "trap_mem");
        step(I_MEM, F_FD, "trap_mem_refill1");
        step(I_MEM, F_FD, "trap_mem_refill2");
        step(I_MEM, MEMST, "mem_after_refill");
        step(I_IDLE, NONE, "mem_after_refill_rel");

        // Dcache stall straddling divide completion defers div_done
        step(I_DIV, DIVST, "div3_start");
        for (int i = 0; i < 30; i++) step(I_IDLE, DIVST, "div3_wait");
        for (int i = 0; i < 3; i++) step(I_MEM, MEMST, "div3_memstall");
        step(I_IDLE, DONE, "div3_deferred_done");
        step(I_IDLE, NONE, "div3_after");

        // Reset mid-divide clears the counter
        step(I_DIV, DIVST, "div4_start");
        for (int i = 0; i < 5; i++) step(I_IDLE, DIVST, "div4_wait");
        #1; rst = 1'b1;
        step(I_IDLE, F_ALL, "rst_mid_div");
        @(posedge clk); #2; rst = 1'b0;
        for (int i = 0; i < 35; i++) step(I_IDLE, NONE, "idle_after_mid_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
